// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified SRAM port: access size codes, master IDs
// and the byte-enable / write-data replication helper.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2
  } access_sz_e;

  typedef enum logic {
    MID_INST = 1'b0,
    MID_DATA = 1'b1
  } mid_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        misaligned;
  } lane_t;

  // Illegal size codes fall into the default arm and report as misaligned.
  function automatic lane_t lane_map(input logic [2:0]  sz,
                                     input logic [1:0]  addr_lo,
                                     input logic [31:0] wdata,
                                     input logic        we);
    lane_t r;
    r = '0;
    case (sz)
      SZ_BYTE: begin
        r.be    = 4'b0001 << addr_lo;
        r.wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        r.be         = 4'b0011 << addr_lo;
        r.wdata      = {2{wdata[15:0]}};
        r.misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        r.be         = 4'b1111;
        r.wdata      = wdata;
        r.misaligned = |addr_lo;
      end
      default: r.misaligned = 1'b1;
    endcase
    if (!we || r.misaligned) r.be = '0;
    return r;
  endfunction

endpackage

// File: rtl/sram_lane_gen.sv
// Combinational byte-lane generator: byte enables, lane-replicated write data
// and misalignment flag from access size and low address bits.
module sram_lane_gen
  import mem_arb_pkg::*;
(
  input  logic [2:0]  sz,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_wdata,
  output logic        misaligned
);

  lane_t lane;

  always_comb begin
    lane       = lane_map(sz, addr_lo, wdata, we);
    sram_we    = lane.be;
    sram_wdata = lane.wdata;
    misaligned = lane.misaligned;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for one 32-bit synchronous SRAM port: data side has fixed
// priority, a starvation counter forces the instruction side through.
module sram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_access_sz,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam int unsigned     CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             tag_valid;
  mid_e             tag_id;
  logic [31:0]      m0_rdata_q;
  logic [31:0]      m1_rdata_q;

  logic [3:0]       lane_we;
  logic [31:0]      lane_wdata;
  logic             lane_mis;

  logic             m1_wins;
  logic             m0_wins;
  logic             m1_issue;
  logic             rd_issue;
  logic             unused_m0_lo;

  assign unused_m0_lo = ^m0_addr[1:0];

  sram_lane_gen u_lane_gen (
    .sz         (m1_access_sz),
    .addr_lo    (m1_addr[1:0]),
    .wdata      (m1_wdata),
    .we         (m1_we),
    .sram_we    (lane_we),
    .sram_wdata (lane_wdata),
    .misaligned (lane_mis)
  );

  // The counter only matters while m0 is actually competing.
  always_comb begin
    m1_wins  = m1_req && (!m0_req || (starve_cnt < LIMIT));
    m0_wins  = m0_req && !m1_wins;
    m1_gnt   = rst_n && m1_wins;
    m0_gnt   = rst_n && m0_wins;
    m1_err   = m1_gnt && lane_mis;
    m1_issue = m1_gnt && !lane_mis;
    sram_en  = m0_gnt || m1_issue;
    rd_issue = m0_gnt || (m1_issue && !m1_we);

    sram_we    = '0;
    sram_wdata = '0;
    sram_addr  = '0;
    if (m1_issue) begin
      sram_we   = lane_we;
      sram_addr = {m1_addr[31:2], 2'b00};
      if (m1_we) sram_wdata = lane_wdata;
    end else if (m0_gnt) begin
      sram_addr = {m0_addr[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (m0_req && !m0_gnt) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_id    <= MID_INST;
    end else begin
      tag_valid <= rd_issue;
      tag_id    <= m1_issue ? MID_DATA : MID_INST;
    end
  end

  assign m0_rvalid = tag_valid && (tag_id == MID_INST);
  assign m1_rvalid = tag_valid && (tag_id == MID_DATA);

  // Each side's read data holds its last returned word while the other side reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (m0_rvalid) m0_rdata_q <= sram_rdata;
      if (m1_rvalid) m1_rdata_q <= sram_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? sram_rdata : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? sram_rdata : m1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small read-only SRAM model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [2:0]  m1_access_sz;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:127];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req       (m0_req),
    .m0_addr      (m0_addr),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_access_sz (m1_access_sz),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .m1_err       (m1_err),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always @(posedge clk)
    if (sram_en && sram_we == 4'b0000) sram_rdata <= mem[sram_addr[8:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
  endtask

  initial begin
    logic exp_m1;
    logic [31:0] exp_cnt;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[7]    = 32'hDEADBEEF;
    mem[8]    = 32'h00000808;
    mem[16]   = 32'h40404040;
    mem[17]   = 32'h44444444;
    mem[32]   = 32'h80808080;
    mem[33]   = 32'h84848484;
    sram_rdata = 32'h0;

    // Reset with both requests held
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_access_sz = 3'd2;
    #2;
    check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    check("rst_sram_en", {31'b0, sram_en}, 32'd0);
    check("rst_sram_we", {28'b0, sram_we}, 32'd0);
    check("rst_m1_err", {31'b0, m1_err}, 32'd0);
    check("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Both requesting: m1 x4 then m0, repeating
    for (int i = 0; i < 10; i++) begin
      exp_m1  = (i % 5) != 4;
      exp_cnt = i % 5;
      #2;
      check($sformatf("starve_m1_gnt%0d", i), {31'b0, m1_gnt}, {31'b0, exp_m1});
      check($sformatf("starve_m0_gnt%0d", i), {31'b0, m0_gnt}, {31'b0, !exp_m1});
      check($sformatf("starve_cnt%0d", i), 32'(dut.starve_cnt), exp_cnt);
      step();
    end
    idle();
    step();
    #2;
    check("idle_sram_en", {31'b0, sram_en}, 32'd0);
    step();

    // m0 read 0x1C alone
    m0_req = 1'b1; m0_addr = 32'h1C;
    #2;
    check("m0rd_en", {31'b0, sram_en}, 32'd1);
    check("m0rd_addr", sram_addr, 32'h1C);
    check("m0rd_we", {28'b0, sram_we}, 32'd0);
    check("m0rd_gnt", {31'b0, m0_gnt}, 32'd1);
    step();
    idle();
    check("m0rd_rvalid", {31'b0, m0_rvalid}, 32'd1);
    check("m0rd_rdata", m0_rdata, 32'hDEADBEEF);
    check("m0rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);

    // Byte write then half write at 0x102
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h102; m1_wdata = 32'h000000A5; m1_access_sz = 3'd0;
    #2;
    check("bw_gnt", {31'b0, m1_gnt}, 32'd1);
    check("bw_err", {31'b0, m1_err}, 32'd0);
    check("bw_we", {28'b0, sram_we}, 32'h4);
    check("bw_addr", sram_addr, 32'h100);
    check("bw_wdata", sram_wdata, 32'hA5A5A5A5);
    step();
    check("bw_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    m1_wdata = 32'h00001234; m1_access_sz = 3'd1;
    #2;
    check("hw_we", {28'b0, sram_we}, 32'hC);
    check("hw_wdata", sram_wdata, 32'h12341234);
    step();
    check("hw_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);

    // Misaligned word read with m0 pending
    m1_we = 1'b0; m1_addr = 32'h106; m1_access_sz = 3'd2;
    m0_req = 1'b1; m0_addr = 32'h20;
    #2;
    check("mis_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    check("mis_err", {31'b0, m1_err}, 32'd1);
    check("mis_en", {31'b0, sram_en}, 32'd0);
    check("mis_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    step();
    m1_req = 1'b0;
    check("mis_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    #2;
    check("mis_m0_next_gnt", {31'b0, m0_gnt}, 32'd1);
    check("mis_m0_next_addr", sram_addr, 32'h20);
    step();
    idle();
    check("mis_m0_rdata", m0_rdata, 32'h00000808);
    check("mis_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    step();

    // Illegal size code reports error
    m1_req = 1'b1; m1_addr = 32'h80; m1_access_sz = 3'd5;
    #2;
    check("illegal_err", {31'b0, m1_err}, 32'd1);
    check("illegal_en", {31'b0, sram_en}, 32'd0);
    step();
    idle();
    step();

    // Alternating reads m0@0x40, m1@0x80, m0@0x44
    m0_req = 1'b1; m0_addr = 32'h40;
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h80; m1_access_sz = 3'd2;
    check("alt0_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    check("alt0_m0_rdata", m0_rdata, 32'h40404040);
    step();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h44;
    check("alt1_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd1);
    check("alt1_m1_rdata", m1_rdata, 32'h80808080);
    check("alt1_m0_hold", m0_rdata, 32'h40404040);
    step();
    idle();
    check("alt2_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd2);
    check("alt2_m0_rdata", m0_rdata, 32'h44444444);
    check("alt2_m1_hold", m1_rdata, 32'h80808080);

    // Reset asserted after an m1 read issue discards the return
    m1_req = 1'b1; m1_addr = 32'h84;
    #2;
    check("rstmid_gnt", {31'b0, m1_gnt}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_gate_gnt", {31'b0, m1_gnt}, 32'd0);
    step();
    check("rstmid_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    idle();
    rst_n = 1'b1;
    step();
    check("rstmid_after", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
